// File: rtl/ysyx_25020037_axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4 arbiter, one whole transaction
// per grant. Define YSYX_25020037_ARB_RR_EN for round-robin between the masters.
module ysyx_25020037_axi_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  // IFU read
  input  logic                m0_arvalid,
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic [ID_W-1:0]     m0_arid,
  input  logic [7:0]          m0_arlen,
  input  logic [2:0]          m0_arsize,
  input  logic [1:0]          m0_arburst,
  output logic                m0_arready,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  output logic                m0_rlast,
  output logic [ID_W-1:0]     m0_rid,
  input  logic                m0_rready,
  // LSU read
  input  logic                m1_arvalid,
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic [ID_W-1:0]     m1_arid,
  input  logic [7:0]          m1_arlen,
  input  logic [2:0]          m1_arsize,
  input  logic [1:0]          m1_arburst,
  output logic                m1_arready,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  output logic                m1_rlast,
  output logic [ID_W-1:0]     m1_rid,
  input  logic                m1_rready,
  // LSU write
  input  logic                m1_awvalid,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic [ID_W-1:0]     m1_awid,
  input  logic [7:0]          m1_awlen,
  input  logic [2:0]          m1_awsize,
  input  logic [1:0]          m1_awburst,
  output logic                m1_awready,
  input  logic                m1_wvalid,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wlast,
  output logic                m1_wready,
  output logic                m1_bvalid,
  output logic [1:0]          m1_bresp,
  output logic [ID_W-1:0]     m1_bid,
  input  logic                m1_bready,
  // Slave
  output logic                s_arvalid,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic [ID_W-1:0]     s_arid,
  output logic [7:0]          s_arlen,
  output logic [2:0]          s_arsize,
  output logic [1:0]          s_arburst,
  input  logic                s_arready,
  input  logic                s_rvalid,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic                s_rlast,
  input  logic [ID_W-1:0]     s_rid,
  output logic                s_rready,
  output logic                s_awvalid,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic [ID_W-1:0]     s_awid,
  output logic [7:0]          s_awlen,
  output logic [2:0]          s_awsize,
  output logic [1:0]          s_awburst,
  input  logic                s_awready,
  output logic                s_wvalid,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wlast,
  input  logic                s_wready,
  input  logic                s_bvalid,
  input  logic [1:0]          s_bresp,
  input  logic [ID_W-1:0]     s_bid,
  output logic                s_bready
);

  typedef enum logic [1:0] {StIdle, StIfuR, StLsuR, StLsuW} state_e;

  state_e state_q, state_d;
  logic   req_w, req_r1, req_r0, pick_ifu;

  assign req_w  = m1_awvalid | m1_wvalid;
  assign req_r1 = m1_arvalid;
  assign req_r0 = m0_arvalid;

`ifdef YSYX_25020037_ARB_RR_EN
  // 1: the LSU held the last grant, so the IFU wins the next contested arbitration.
  logic lsu_last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lsu_last_q <= 1'b0;
    end else if (state_q == StIdle && state_d != StIdle) begin
      lsu_last_q <= (state_d != StIfuR);
    end
  end

  assign pick_ifu = req_r0 & (~(req_w | req_r1) | lsu_last_q);
`else
  assign pick_ifu = req_r0 & ~(req_w | req_r1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (pick_ifu) begin
          state_d = StIfuR;
        end else if (req_w) begin
          state_d = StLsuW;
        end else if (req_r1) begin
          state_d = StLsuR;
        end
      end
      StIfuR: if (s_rvalid && m0_rready && s_rlast) state_d = StIdle;
      StLsuR: if (s_rvalid && m1_rready && s_rlast) state_d = StIdle;
      StLsuW: if (s_bvalid && m1_bready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    m0_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = 2'b00;
    m0_rlast   = 1'b0;
    m0_rid     = '0;
    m1_arready = 1'b0;
    m1_rvalid  = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = 2'b00;
    m1_rlast   = 1'b0;
    m1_rid     = '0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bvalid  = 1'b0;
    m1_bresp   = 2'b00;
    m1_bid     = '0;
    s_arvalid  = 1'b0;
    s_araddr   = '0;
    s_arid     = '0;
    s_arlen    = 8'h00;
    s_arsize   = 3'h2;
    s_arburst  = 2'b00;
    s_rready   = 1'b0;
    s_awvalid  = 1'b0;
    s_awaddr   = '0;
    s_awid     = '0;
    s_awlen    = 8'h00;
    s_awsize   = 3'h2;
    s_awburst  = 2'b00;
    s_wvalid   = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_wlast    = 1'b0;
    s_bready   = 1'b0;
    unique case (state_q)
      StIfuR: begin
        s_arvalid  = m0_arvalid;
        s_araddr   = m0_araddr;
        s_arid     = m0_arid;
        s_arlen    = m0_arlen;
        s_arsize   = m0_arsize;
        s_arburst  = m0_arburst;
        m0_arready = s_arready;
        m0_rvalid  = s_rvalid;
        m0_rdata   = s_rdata;
        m0_rresp   = s_rresp;
        m0_rlast   = s_rlast;
        m0_rid     = s_rid;
        s_rready   = m0_rready;
      end
      StLsuR: begin
        s_arvalid  = m1_arvalid;
        s_araddr   = m1_araddr;
        s_arid     = m1_arid;
        s_arlen    = m1_arlen;
        s_arsize   = m1_arsize;
        s_arburst  = m1_arburst;
        m1_arready = s_arready;
        m1_rvalid  = s_rvalid;
        m1_rdata   = s_rdata;
        m1_rresp   = s_rresp;
        m1_rlast   = s_rlast;
        m1_rid     = s_rid;
        s_rready   = m1_rready;
      end
      StLsuW: begin
        s_awvalid  = m1_awvalid;
        s_awaddr   = m1_awaddr;
        s_awid     = m1_awid;
        s_awlen    = m1_awlen;
        s_awsize   = m1_awsize;
        s_awburst  = m1_awburst;
        m1_awready = s_awready;
        s_wvalid   = m1_wvalid;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        s_wlast    = m1_wlast;
        m1_wready  = s_wready;
        m1_bvalid  = s_bvalid;
        m1_bresp   = s_bresp;
        m1_bid     = s_bid;
        s_bready   = m1_bready;
      end
      default: ;
    endcase
  end

endmodule
